// File: rtl/tmr_arb_pkg.sv
// Shared types for the shared timer arbiter: FSM state encoding, default widths and
// a one-hot to index helper sized for up to 8 requesters.
package tmr_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int NUM_REQ_DEF  = 4;
   localparam int CNT_W_DEF    = 16;
   localparam int TICK_NUM_DEF = 4;
   localparam int SEL_W_DEF    = 2;
   localparam int IDX_W        = 3;

   function automatic logic [IDX_W-1:0] onehot2idx(input logic [7:0] oh);
      onehot2idx = '0;
      for (int i = 0; i < 8; i++)
         if (oh[i]) onehot2idx = IDX_W'(i);
   endfunction

endpackage

// File: rtl/timer_share_arb_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter
   import tmr_arb_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEF
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] win
);

   int   idx;
   logic found;

   always_comb begin
      win   = '0;
      found = 1'b0;
      idx   = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = (int'(ptr) + i) % NUM_REQ;
         if (!found && req[idx]) begin
            win[idx] = 1'b1;
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/timer_share_arb.sv
// One down-counter shared round-robin between NUM_REQ delay requesters.
// Optional status ports (cnt_rem, owner_id) are enabled by defining TMR_ARB_STATUS_EN.
module timer_share_arb
   import tmr_arb_pkg::*;
#(
   parameter int NUM_REQ  = NUM_REQ_DEF,
   parameter int CNT_W    = CNT_W_DEF,
   parameter int TICK_NUM = TICK_NUM_DEF,
   parameter int SEL_W    = SEL_W_DEF
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [TICK_NUM-1:0]      tick_in,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*CNT_W-1:0] req_len,
   input  logic [NUM_REQ*SEL_W-1:0] req_sel,
   output logic [NUM_REQ-1:0]       gnt,
   output logic [NUM_REQ-1:0]       done,
   output logic                     busy
`ifdef TMR_ARB_STATUS_EN
   ,
   output logic [CNT_W-1:0]         cnt_rem,
   output logic [2:0]               owner_id
`endif
);

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic [SEL_W-1:0]     sel_q, sel_d;
   logic [NUM_REQ-1:0]   gnt_q, gnt_d, done_q, done_d;
   logic                 busy_q, busy_d;
   logic [IDX_W-1:0]     ptr_q, ptr_d;
   logic [NUM_REQ-1:0]   win;
   logic [7:0]           win8;
   logic [IDX_W-1:0]     win_idx;
   logic [CNT_W-1:0]     win_len;
   logic [SEL_W-1:0]     win_sel;
   logic                 tick;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .req (req),
      .ptr (ptr_q),
      .win (win)
   );

   always_comb begin
      win_len = '0;
      win_sel = '0;
      win8    = '0;
      win8[NUM_REQ-1:0] = win;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win[i]) begin
            win_len = req_len[i*CNT_W +: CNT_W];
            win_sel = req_sel[i*SEL_W +: SEL_W];
         end
      end
      win_idx = onehot2idx(win8);
   end

   // Unsupported tick selects fall back to base 0
   always_comb begin
      tick = tick_in[0];
      if (int'(sel_q) < TICK_NUM) tick = tick_in[sel_q];
   end

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      sel_d   = sel_q;
      gnt_d   = gnt_q;
      done_d  = '0;
      busy_d  = busy_q;
      ptr_d   = ptr_q;
      case (state_q)
         IDLE: begin
            if (|req) begin
               count_d = win_len;
               sel_d   = win_sel;
               gnt_d   = win;
               busy_d  = 1'b1;
               ptr_d   = (int'(win_idx) == NUM_REQ-1) ? '0 : win_idx + 1'b1;
               if (win_len == '0) begin
                  state_d = DONE;
                  done_d  = win;
               end else begin
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            // Owner dropping req wins over a final tick in the same cycle
            if ((req & gnt_q) == '0) begin
               state_d = IDLE;
               gnt_d   = '0;
               busy_d  = 1'b0;
               count_d = '0;
            end else if (tick) begin
               count_d = count_q - CNT_W'(1);
               if (count_q == CNT_W'(1)) begin
                  state_d = DONE;
                  done_d  = gnt_q;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
            gnt_d   = '0;
            busy_d  = 1'b0;
            count_d = '0;
         end
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
            busy_d  = 1'b0;
            count_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         count_q <= '0;
         sel_q   <= '0;
         gnt_q   <= '0;
         done_q  <= '0;
         busy_q  <= 1'b0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         sel_q   <= sel_d;
         gnt_q   <= gnt_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         ptr_q   <= ptr_d;
      end
   end

   assign gnt  = gnt_q;
   assign done = done_q;
   assign busy = busy_q;

`ifdef TMR_ARB_STATUS_EN
   logic [7:0] gnt8;
   always_comb begin
      gnt8 = '0;
      gnt8[NUM_REQ-1:0] = gnt_q;
   end
   // count is cleared on every exit from RUN, so it already reads 0 elsewhere
   assign cnt_rem  = count_q;
   assign owner_id = onehot2idx(gnt8);
`endif

endmodule
